seg_scan_ctrl: RTL and testbench

Scan controller for the 4-digit multiplexed 7-segment display. Holds a shadow copy of the 16-bit BCD value and loads new values only at frame boundaries through a req/ack handshake, so no tearing is visible. It time-slices the digits and inserts an anti-ghosting blank gap before each digit, applies PWM brightness, and can suppress leading zeros. It drives the digit nibble into the BCD-to-7-segment encoder and drives the per-digit enables.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_slot_timer.sv | 98 +++++++++
 rtl/seg_scan_ctrl.sv | 91 +++++++++
 tb/tb_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 4-digit multiplexed 7-segment scan controller.
package seg_scan_pkg;

  // Phase of the current digit slot.
  typedef enum logic [1:0] {
    PH_BLANK,
    PH_ON,
    PH_OFF
  } phase_t;

  // Digit index; digit 0 is the leftmost digit.
  typedef logic [1:0] digit_t;

  // Pick the nibble for digit idx out of the 16-bit BCD value (digit 0 = [15:12]).
  function automatic logic [3:0] nibble_sel(input logic [15:0] value, input digit_t idx);
    case (idx)
      2'd0:    return value[15:12];
      2'd1:    return value[11:8];
      2'd2:    return value[7:4];
      default: return value[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot/digit timing for the scan controller: cnt/d counters, per-frame brightness
// latch, on-time computation and phase decode. Everything the output stage needs
// is presented as next-state values so registered outputs line up with the
// cycle the counters show.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = 4096,
  parameter int BLANK_CYCLES = 256,
  parameter int BRIGHT_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BRIGHT_W-1:0] brightness,
  output digit_t              d_nxt,
  output phase_t              phase_nxt,
  output logic                slot_first_nxt,
  output logic                frame_first_nxt,
  output logic                frame_boundary
);

  localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  // Wide enough to hold BLANK_CYCLES + on_len without overflow.
  localparam int EXT_W  = CNT_W + 2;
  // Full-width product of (bl+1) and the active slot length.
  localparam int PROD_W = CNT_W + BRIGHT_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [EXT_W-1:0]  BLANK_X  = EXT_W'(BLANK_CYCLES);
  localparam logic [PROD_W-1:0] ACTIVE_P = PROD_W'(SLOT_CYCLES - BLANK_CYCLES);

  // run_q is low only until the first clock after reset release. That first
  // edge holds the counters at 0/0 so the output registers present the first
  // frame cycle, with frame_start, in the cycle right after it.
  logic                run_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  digit_t              d_q;
  logic [BRIGHT_W-1:0] bl_q;
  logic [BRIGHT_W-1:0] bl_nxt;
  logic [PROD_W-1:0]   prod;
  logic [EXT_W-1:0]    on_len;
  logic [EXT_W-1:0]    cnt_x;

  assign frame_boundary = run_q && (cnt_q == CNT_LAST) && (d_q == 2'd3);

  // Next counter values: cnt wraps at the slot end and advances the digit.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt = '0;
    d_nxt   = '0;
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_nxt = '0;
        d_nxt   = d_q + 2'd1;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
        d_nxt   = d_q;
      end
    end
  end

  assign slot_first_nxt  = (cnt_nxt == '0);
  assign frame_first_nxt = slot_first_nxt && (d_nxt == 2'd0);

  // Brightness is taken once per frame, on entry to its first cycle.
  assign bl_nxt = frame_first_nxt ? brightness : bl_q;
  assign prod   = (PROD_W'(bl_nxt) + PROD_W'(1)) * ACTIVE_P;
  assign on_len = EXT_W'(prod >> BRIGHT_W);
  assign cnt_x  = EXT_W'(cnt_nxt);

  // Phase decode for the cycle the counters are about to show.
  always_comb begin
    phase_nxt = PH_OFF;
    if (cnt_x < BLANK_X) begin
      phase_nxt = PH_BLANK;
    end else if (cnt_x < BLANK_X + on_len) begin
      phase_nxt = PH_ON;
    end
  end

  // Counter and brightness state; reset aborts the scan immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      d_q   <= '0;
      bl_q  <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_nxt;
      d_q   <= d_nxt;
      bl_q  <= bl_nxt;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller: tear-free shadow register
// loaded at frame boundaries via req/ack, anti-ghosting blank gap, PWM
// brightness and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = 4096,
  parameter int BLANK_CYCLES = 256,
  parameter int BRIGHT_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         bcd_in,
  input  logic                load_req,
  output logic                load_ack,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                lz_blank,
  output logic [3:0]          digit_bcd,
  output logic [3:0]          en,
  output logic                frame_start
);

  digit_t      d_nxt;
  phase_t      phase_nxt;
  logic        slot_first_nxt;
  logic        frame_first_nxt;
  logic        frame_boundary;
  logic [15:0] shadow_q;
  logic [15:0] shadow_nxt;
  logic        lz_q;
  logic        lz_nxt;
  logic        suppress_nxt;

  // True when digit k and every digit to its left are zero; digit 3 always shows.
  function automatic logic leading_zero(input logic [15:0] value, input digit_t k);
    case (k)
      2'd0:    return value[15:12] == 4'd0;
      2'd1:    return value[15:8]  == 8'd0;
      2'd2:    return value[15:4]  == 12'd0;
      default: return 1'b0;
    endcase
  endfunction

  seg_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BRIGHT_W    (BRIGHT_W)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .brightness     (brightness),
    .d_nxt          (d_nxt),
    .phase_nxt      (phase_nxt),
    .slot_first_nxt (slot_first_nxt),
    .frame_first_nxt(frame_first_nxt),
    .frame_boundary (frame_boundary)
  );

  // The ack is the boundary cycle itself; dropping load_req earlier cancels it.
  assign load_ack     = frame_boundary && load_req;
  assign shadow_nxt   = load_ack ? bcd_in : shadow_q;
  // lz_blank is sampled per slot so a change never cuts a digit mid-slot.
  assign lz_nxt       = slot_first_nxt ? lz_blank : lz_q;
  assign suppress_nxt = lz_nxt && leading_zero(shadow_nxt, d_nxt);

  // Shadow value and per-slot suppression mode.
  // NOTE: the shadow is a plain 16-bit register, so it gets an async reset like any other state and comes up showing 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      lz_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_nxt;
      lz_q     <= lz_nxt;
    end
  end

  // Output registers, fed from next-state values so they match the shown cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en          <= '0;
      digit_bcd   <= '0;
      frame_start <= 1'b0;
    end else begin
      en          <= (phase_nxt == PH_ON && !suppress_nxt) ? (4'b0001 << d_nxt) : 4'b0000;
      digit_bcd   <= nibble_sel(shadow_nxt, d_nxt);
      frame_start <= frame_first_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios followed by random
// stimulus, all checked every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int S  = 16;
  localparam int B  = 4;
  localparam int BW = 2;
  localparam int FRAME = 4 * S;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bcd_in;
  logic          load_req;
  logic          load_ack;
  logic [BW-1:0] brightness;
  logic          lz_blank;
  logic [3:0]    digit_bcd;
  logic [3:0]    en;
  logic          frame_start;

  seg_scan_ctrl #(
    .SLOT_CYCLES (S),
    .BLANK_CYCLES(B),
    .BRIGHT_W    (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .brightness (brightness),
    .lz_blank   (lz_blank),
    .digit_bcd  (digit_bcd),
    .en         (en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: position in the frame plus values latched per frame/slot.
  bit          primed;
  int          pos;
  logic [15:0] sh_m;
  int          bl_m;
  bit          lz_m;
  bit          last_ack;
  bit          drop_after_ack;
  int          ack_seen;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    int d;
    int c;
    int on_len;
    logic [15:0] upper;
    logic [3:0] e_en;
    logic [3:0] e_dig;
    logic e_fs;
    logic e_ack;
    #1;
    e_en = 4'b0;
    e_dig = 4'h0;
    e_fs = 1'b0;
    e_ack = 1'b0;
    if (primed) begin
      d = pos / S;
      c = pos % S;
      on_len = ((bl_m + 1) * (S - B)) >> BW;
      upper = sh_m >> (12 - 4 * d);
      e_dig = upper[3:0];
      if (c >= B && c < B + on_len && !(lz_m && d < 3 && upper == 16'h0))
        e_en = 4'(1 << d);
      e_fs = (pos == 0);
      e_ack = (pos == FRAME - 1) && load_req;
    end
    check("en", 16'(en), 16'(e_en));
    check("digit_bcd", 16'(digit_bcd), 16'(e_dig));
    check("frame_start", 16'(frame_start), 16'(e_fs));
    check("load_ack", 16'(load_ack), 16'(e_ack));
    ack_seen += int'(load_ack);
    last_ack = e_ack;
    @(posedge clk);
    if (!primed) begin
      primed = 1'b1;
      pos = 0;
      bl_m = int'(brightness);
      lz_m = lz_blank;
    end else begin
      if (e_ack) sh_m = bcd_in;
      pos = (pos + 1) % FRAME;
      if (pos % S == 0) lz_m = lz_blank;
      if (pos == 0) bl_m = int'(brightness);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      if (drop_after_ack && last_ack) load_req = 1'b0;
    end
  endtask

  // Assert reset at a negedge, confirm outputs clear at once, release two cycles later.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_en", 16'(en), 16'h0);
    check("rst_digit", 16'(digit_bcd), 16'h0);
    check("rst_ack", 16'(load_ack), 16'h0);
    check("rst_fs", 16'(frame_start), 16'h0);
    sh_m = 16'h0;
    primed = 1'b0;
    @(negedge clk);
    check("rst_hold_en", 16'(en), 16'h0);
    check("rst_hold_fs", 16'(frame_start), 16'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < 4; i++)
      v = {v[11:0], ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15))};
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    bcd_in = 16'h1234;
    load_req = 1'b1;
    brightness = 2'd3;
    lz_blank = 1'b0;
    drop_after_ack = 1'b1;
    ack_seen = 0;
    @(negedge clk);
    do_reset();

    // Full brightness; 1234 loads at the first boundary and shows in frame 1.
    run(1 + 2 * FRAME);

    // Brightness 0 requested mid-frame; applies from the next frame start.
    run(20);
    brightness = 2'd0;
    run(2 * FRAME);

    // Mid-frame load of 0042: exactly one ack, at the boundary.
    run(10);
    ack_seen = 0;
    bcd_in = 16'h0042;
    load_req = 1'b1;
    run(2 * FRAME);
    check("ack_count_0042", 16'(ack_seen), 16'd1);

    // Leading-zero suppression on 0042, then on 0000.
    brightness = 2'd2;
    run(5);
    lz_blank = 1'b1;
    run(2 * FRAME);
    bcd_in = 16'h0000;
    load_req = 1'b1;
    run(2 * FRAME);

    // Reset mid-slot with a load pending.
    run(20);
    bcd_in = 16'h9999;
    load_req = 1'b1;
    drop_after_ack = 1'b0;
    do_reset();
    run(1 + FRAME);

    // Request held for three frames: one ack per boundary.
    ack_seen = 0;
    run(3 * FRAME);
    check("ack_count_held", 16'(ack_seen), 16'd3);

    // Request withdrawn before the boundary: no ack.
    load_req = 1'b0;
    run((5 - pos + FRAME) % FRAME);
    load_req = 1'b1;
    run(30);
    load_req = 1'b0;
    ack_seen = 0;
    run(FRAME);
    check("ack_count_cancel", 16'(ack_seen), 16'd0);

    // Random traffic: brightness/lz changes at any time, loads with cancels.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) brightness = BW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if (!load_req) begin
        if ($urandom_range(0, 19) == 0) begin
          bcd_in = rand_bcd();
          load_req = 1'b1;
        end
      end else if ((last_ack && $urandom_range(0, 3) != 0) || $urandom_range(0, 79) == 0) begin
        load_req = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
